fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer between the PC register and instruction memory.
- On `start`, samples the current PC and issues a memory read. Waits for `mem_ready`, latches the instruction word into IR, then emits a one-cycle PC-increment enable with `PC+1`.
- The PC register consumes `pc_inc_en`/`pc_d` as its enable/data inputs.

Parameters:
- MEM_TIMEOUT, 15, max cycles in REQ without `mem_ready` before abort; must be >= 1 (only used with FETCH_TIMEOUT_EN).
- IR_RESET, 32'h0000_0000, value loaded into `ir_out` on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  synchronous, active-high reset.
- start  in  1  fetch request from control unit; sampled only in IDLE.
- stall  in  1  downstream not ready; holds DONE.
- pc_q  in  32  current PC from PC register.
- mem_addr  out  32  instruction memory address.
- mem_rd  out  1  memory read strobe.
- mem_data  in  32  instruction word from memory.
- mem_ready  in  1  memory data valid; sampled only in REQ.
- ir_out  out  32  latched instruction register.
- ir_valid  out  1  `ir_out` holds a freshly fetched instruction.
- pc_d  out  32  next PC value (latched address + 1).
- pc_inc_en  out  1  one-cycle enable to PC register.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (`clr`=1 at a rising edge):
  - state to IDLE; `ir_out`=IR_RESET.
  - `mem_addr`, `pc_d`=0; `mem_rd`, `ir_valid`, `pc_inc_en`, `busy`, `fetch_err`=0; timeout counter=0.
  - `clr` takes priority over all other inputs.
  - `clr` mid-fetch aborts the fetch: no IR update, no `pc_inc_en`, and the abort is not flagged as an error.
- States:
  - IDLE: outputs idle.
    - `start`=1: `addr_reg<=pc_q`, `fetch_err<=0`, counter<=0, go to REQ.
    - `start`=0: stay in IDLE.
  - REQ: `mem_rd`=1, `mem_addr`=`addr_reg`, `busy`=1.
    - `mem_ready`=1: `ir_out<=mem_data`, go to DONE.
    - Otherwise increment counter.
  - DONE: `ir_valid`=1, `pc_d`=`addr_reg`+1, `mem_rd`=0.
    - `pc_inc_en`=1 only on the first DONE cycle, tracked by an internal first-cycle flag.
    - `stall`=1: stay in DONE with `ir_valid` held and `pc_inc_en`=0 after the first cycle.
    - `stall`=0: go to IDLE.
  - ERR (timeout only): `fetch_err<=1`, `mem_rd`=0, one cycle, then IDLE.
- Latency:
  - `start` sampled at edge N → `mem_rd` high in cycle N+1.
  - `mem_ready` sampled at edge N+1 → `ir_valid`/`pc_inc_en` in cycle N+2.
  - Minimum `start`→`ir_valid` latency: 2 cycles.
- Outputs `mem_rd`, `ir_valid`, `pc_inc_en`, and `busy` are decoded from state registers; no combinational path from inputs to outputs.
- Arithmetic: `pc_d` = `addr_reg` + 1, modulo 2^32; 32'hFFFF_FFFF wraps to 32'h0000_0000.
- Boundaries:
  - `start` while `busy` is ignored, with no queuing.
  - `pc_q` changes after the sampling edge are ignored.
  - `mem_ready` outside REQ is ignored.
  - `mem_ready` and timeout on the same edge: ready wins.
  - `start` in the same cycle DONE exits is ignored; it is seen next cycle in IDLE.
  - `fetch_err` persists until the next accepted `start` or `clr`.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - Counter of width clog2(MEM_TIMEOUT+1) runs in REQ.
  - REQ goes to ERR when the counter reaches MEM_TIMEOUT with `mem_ready` still 0.
  - With MEM_TIMEOUT=15, ERR is entered after 15 REQ cycles.
- FETCH_TIMEOUT_EN undefined:
  - No counter and no ERR state; REQ waits indefinitely.
  - `fetch_err` is tied to 0.

Test Plan:
- Reset then idle: `clr`=1 for 2 cycles → all outputs 0, `ir_out`=0, `busy`=0; `start`=0 for 5 cycles → no change.
- Basic fetch: `pc_q`=32'h10, `start` pulse, memory returns 32'hA5A5_0001 with `mem_ready` on the first REQ cycle → `mem_rd`=1 and `mem_addr`=32'h10 in cycle 1; `ir_out`=32'hA5A5_0001, `ir_valid`=1, `pc_inc_en`=1, `pc_d`=32'h11 in cycle 2; IDLE in cycle 3.
- Wait states plus stall: `mem_ready` delayed 3 cycles, `stall`=1 for 4 cycles in DONE → `mem_rd` high 4 cycles; `ir_valid` high 4 cycles; `pc_inc_en` exactly 1 cycle; `start` during `busy` ignored.
- Wrap: `pc_q`=32'hFFFF_FFFF fetch → `pc_d`=32'h0000_0000.
- Timeout (FETCH_TIMEOUT_EN, MEM_TIMEOUT=15): `mem_ready` never asserted → `fetch_err`=1 after 15 REQ cycles; no `pc_inc_en`; IR unchanged; next `start` clears `fetch_err`. Without the macro: `busy` stays high and `fetch_err`=0.
- Reset mid-fetch: `clr`=1 during REQ → next cycle IDLE, `mem_rd`=0, IR unchanged, no `pc_inc_en`, `fetch_err`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: samples PC on start, reads instruction memory,
// latches IR and pulses a PC-increment. Optional timeout abort: FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter logic [31:0] IR_RESET    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] pc_q,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    output logic [31:0] pc_d,
    output logic        pc_inc_en,
    output logic        busy,
    output logic        fetch_err
);

    if (MEM_TIMEOUT < 1) begin : g_param_check
        $error("fetch_unit: MEM_TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
`ifdef FETCH_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        first_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout;

    // Compare against MEM_TIMEOUT-1 so ERR follows exactly MEM_TIMEOUT REQ cycles.
    assign timeout   = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign fetch_err = err_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!mem_ready) cnt_q <= cnt_q + 1'b1;
                end
                S_ERR:   err_q <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ir_out  <= IR_RESET;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == S_REQ) && mem_ready;
            if (state_q == S_IDLE && start) addr_q <= pc_q;
            if (state_q == S_REQ && mem_ready) ir_out <= mem_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (mem_ready) state_d = S_DONE;
`ifdef FETCH_TIMEOUT_EN
                else if (timeout) state_d = S_ERR;
`endif
            end
            S_DONE: if (!stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state_q == S_REQ);
        busy      = (state_q != S_IDLE);
        ir_valid  = (state_q == S_DONE);
        pc_inc_en = (state_q == S_DONE) && first_q;
        mem_addr  = (state_q == S_REQ)  ? addr_q : '0;
        pc_d      = (state_q == S_DONE) ? addr_q + 32'd1 : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IR/PC pairs are queued at start
// and checked when pc_inc_en fires.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc_q = '0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [31:0] pc_d;
    logic        pc_inc_en;
    logic        busy;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] ir_model;
    int          n_tests = 0;
    int          n_fail  = 0;

    fetch_unit #(.MEM_TIMEOUT(15), .IR_RESET(32'h0000_0000)) dut (
        .clk(clk), .clr(clr), .start(start), .stall(stall), .pc_q(pc_q),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready), .ir_out(ir_out), .ir_valid(ir_valid),
        .pc_d(pc_d), .pc_inc_en(pc_inc_en), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop(input string name);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: pc_inc_en with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            ir_model = e.ir;
            if (ir_out !== e.ir || pc_d !== e.pc) begin
                n_fail++;
                $display("FAIL %s: got ir=%h pc_d=%h, expected ir=%h pc_d=%h",
                         name, ir_out, pc_d, e.ir, e.pc);
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        ir_model = 32'h0;
        n_tests++;
        if ({mem_rd, ir_valid, pc_inc_en, busy, fetch_err} !== 5'b0 ||
            mem_addr !== 32'h0 || pc_d !== 32'h0 || ir_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: got ctl=%b addr=%h pc_d=%h ir=%h, expected all zero",
                     {mem_rd, ir_valid, pc_inc_en, busy, fetch_err}, mem_addr, pc_d, ir_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({mem_rd, ir_valid, pc_inc_en, busy, fetch_err} !== 5'b0 || ir_out !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_hold: got ctl=%b ir=%h, expected 0/0",
                         {mem_rd, ir_valid, pc_inc_en, busy, fetch_err}, ir_out);
            end
        end
    endtask

    task automatic test_basic();
        pc_q = 32'h10;
        mem_data = 32'hA5A5_0001;
        mem_ready = 1'b1;
        start = 1'b1;
        sb.push_back('{ir: 32'hA5A5_0001, pc: 32'h11});
        tick();
        start = 1'b0;
        pc_q = 32'h999;
        n_tests++;
        if ({mem_rd, busy, ir_valid} !== 3'b110 || mem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL basic_req: got rd/busy/iv=%b addr=%h, expected 110 addr=00000010",
                     {mem_rd, busy, ir_valid}, mem_addr);
        end
        tick();
        mem_ready = 1'b0;
        n_tests++;
        if ({ir_valid, pc_inc_en, mem_rd} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_done: got iv/inc/rd=%b, expected 110", {ir_valid, pc_inc_en, mem_rd});
        end
        check_pop("basic_data");
        tick();
        n_tests++;
        if ({busy, ir_valid, pc_inc_en, mem_rd} !== 4'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy/iv/inc/rd=%b, expected 0000",
                     {busy, ir_valid, pc_inc_en, mem_rd});
        end
    endtask

    task automatic test_wait_stall();
        int n_rd = 0, n_iv = 0, n_inc = 0, n_busy = 0;
        pc_q = 32'h200;
        start = 1'b1;
        sb.push_back('{ir: 32'h1234_5678, pc: 32'h201});
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (mem_rd) n_rd++;
            if (ir_valid) n_iv++;
            if (busy) n_busy++;
            if (pc_inc_en) begin
                n_inc++;
                check_pop("stall_data");
            end
            // start stays high while busy and on the DONE exit cycle; both must be ignored
            pc_q      = 32'hDEAD_0000;
            start     = (c <= 8);
            mem_ready = (c == 4);
            mem_data  = (c == 4) ? 32'h1234_5678 : 32'hBAD0_BAD0;
            stall     = (c >= 4 && c <= 7);
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (n_rd != 4 || n_iv != 4 || n_inc != 1 || n_busy != 8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_stall: got rd=%0d iv=%0d inc=%0d busy=%0d end_busy=%b, expected 4 4 1 8 0",
                     n_rd, n_iv, n_inc, n_busy, busy);
        end
    endtask

    task automatic test_wrap();
        bit got = 0;
        pc_q = 32'hFFFF_FFFF;
        mem_data = 32'hC0DE_F00D;
        mem_ready = 1'b1;
        start = 1'b1;
        sb.push_back('{ir: 32'hC0DE_F00D, pc: 32'h0000_0000});
        tick();
        start = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (pc_inc_en) begin
                got = 1;
                check_pop("wrap_data");
            end else tick();
        end
        mem_ready = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_wait: got no pc_inc_en within 8 cycles, expected one");
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n_rd = 0, n_inc = 0;
        bit seen = 0;
        pc_q = 32'h300;
        mem_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen; i++) begin
            if (fetch_err) seen = 1;
            else begin
                if (mem_rd) n_rd++;
                if (pc_inc_en) n_inc++;
                tick();
            end
        end
        n_tests++;
        if (!seen || n_rd != 15 || n_inc != 0 || ir_out !== ir_model || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: got err=%b rd=%0d inc=%0d ir=%h busy=%b, expected 1 15 0 %h 0",
                     seen, n_rd, n_inc, ir_out, busy, ir_model);
        end
        tick();
        n_tests++;
        if (fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", fetch_err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (fetch_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b busy=%b expected 0 1", fetch_err, busy);
        end
`else
        for (int i = 0; i < 20; i++) begin
            if (busy && mem_rd && !fetch_err && !pc_inc_en) n_rd++;
            if (fetch_err) seen = 1;
            tick();
        end
        n_tests++;
        if (n_rd != 20 || seen) begin
            n_fail++;
            $display("FAIL no_timeout: got waiting_cycles=%0d err_seen=%b, expected 20 0", n_rd, seen);
        end
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ir_model = 32'h0;
    endtask

    task automatic test_clr_mid_fetch();
        pc_q = 32'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL clr_pre: got rd=%b addr=%h expected 1 00000040", mem_rd, mem_addr);
        end
        clr = 1'b1;
        mem_ready = 1'b1;
        mem_data = 32'hFFFF_0000;
        tick();
        clr = 1'b0;
        mem_ready = 1'b0;
        n_tests++;
        if ({busy, mem_rd, pc_inc_en, ir_valid, fetch_err} !== 5'b0 || ir_out !== ir_model) begin
            n_fail++;
            $display("FAIL clr_abort: got ctl=%b ir=%h expected 00000 %h",
                     {busy, mem_rd, pc_inc_en, ir_valid, fetch_err}, ir_out, ir_model);
        end
        tick();
        n_tests++;
        if (pc_inc_en !== 1'b0 || ir_valid !== 1'b0 || ir_out !== ir_model) begin
            n_fail++;
            $display("FAIL clr_after: got inc=%b iv=%b ir=%h expected 0 0 %h",
                     pc_inc_en, ir_valid, ir_out, ir_model);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_stall();
        test_wrap();
        test_timeout();
        test_clr_mid_fetch();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
